// File: rtl/clk_strobe_gen_pkg.sv
// Shared types and helpers for the multi-channel strobe generator.
package clk_strobe_gen_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        RUN       = 2'd2
    } state_t;

    // Width of the settle counter; never narrower than one bit.
    function automatic int settle_w(input int lock_dly);
        return (lock_dly > 1) ? $clog2(lock_dly) : 1;
    endfunction

endpackage

// File: rtl/clk_strobe_ch.sv
// One strobe channel: shadow div/phase, free-running counter, reload and strobe decode.
module clk_strobe_ch #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             reload,
    input  logic             cfg_load,
    input  logic [DIV_W-1:0] div,
    input  logic [DIV_W-1:0] phase,
    output logic             strobe
);
    logic [DIV_W-1:0] div_sh, ph_sh, cnt;
    logic [DIV_W-1:0] div_nx, ph_nx, div_eff, div_eff_nx, ph_eff_nx;

    // Reload uses the values being latched this cycle, so a cfg_load takes effect immediately.
    always_comb begin
        div_nx     = cfg_load ? div   : div_sh;
        ph_nx      = cfg_load ? phase : ph_sh;
        div_eff_nx = (div_nx == '0) ? DIV_W'(1) : div_nx;
        ph_eff_nx  = (ph_nx > div_eff_nx - DIV_W'(1)) ? div_eff_nx - DIV_W'(1) : ph_nx;
        div_eff    = (div_sh == '0) ? DIV_W'(1) : div_sh;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_sh <= DIV_W'(1);
            ph_sh  <= '0;
            cnt    <= '0;
        end else begin
            div_sh <= div_nx;
            ph_sh  <= ph_nx;
            if (reload)
                cnt <= ph_eff_nx;
            else if (run)
                cnt <= (cnt == div_eff - DIV_W'(1)) ? '0 : cnt + DIV_W'(1);
        end
    end

    assign strobe = run && (cnt == div_eff - DIV_W'(1));

endmodule

// File: rtl/clk_strobe_gen.sv
// Lock-gated multi-channel strobe generator with settle delay and sticky loss-of-lock.
// Optional CLK_STROBE_GEN_LOCK_SYNC_EN adds a 2-flop synchronizer on pll_locked.
module clk_strobe_gen
    import clk_strobe_gen_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int DIV_W    = 16,
    parameter int LOCK_DLY = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    pll_locked,
    input  logic [NUM_CH*DIV_W-1:0] div,
    input  logic [NUM_CH*DIV_W-1:0] phase,
    input  logic                    cfg_load,
    output logic [NUM_CH-1:0]       strobe,
    output logic                    ready,
    output logic                    lost_lock
);
    localparam int SW = settle_w(LOCK_DLY);

    logic          lock_s;
    state_t        state, state_nx;
    logic [SW-1:0] settle_cnt;
    logic          lost_q, lock_drop, run, reload;

`ifdef CLK_STROBE_GEN_LOCK_SYNC_EN
    logic [1:0] lock_sync;
    always_ff @(posedge clk) begin
        if (!rst_n) lock_sync <= '0;
        else        lock_sync <= {lock_sync[0], pll_locked};
    end
    assign lock_s = lock_sync[1];
`else
    assign lock_s = pll_locked;
`endif

    always_comb begin
        state_nx  = state;
        lock_drop = 1'b0;
        unique case (state)
            WAIT_LOCK: if (lock_s) state_nx = SETTLE;
            SETTLE: begin
                if (!lock_s) begin
                    state_nx  = WAIT_LOCK;
                    lock_drop = 1'b1;
                end else if (settle_cnt == SW'(LOCK_DLY - 1)) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_nx  = WAIT_LOCK;
                    lock_drop = 1'b1;
                end
            end
            default: state_nx = WAIT_LOCK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= WAIT_LOCK;
            settle_cnt <= '0;
            lost_q     <= 1'b0;
        end else begin
            state      <= state_nx;
            settle_cnt <= (state == SETTLE) ? settle_cnt + SW'(1) : '0;
            // A lock drop outranks a clear from cfg_load in the same cycle.
            if (lock_drop)     lost_q <= 1'b1;
            else if (cfg_load) lost_q <= 1'b0;
        end
    end

    assign run       = (state == RUN);
    assign reload    = (state == SETTLE && state_nx == RUN) || (run && cfg_load);
    assign ready     = run;
    assign lost_lock = lost_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clk_strobe_ch #(.DIV_W(DIV_W)) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .run      (run),
            .reload   (reload),
            .cfg_load (cfg_load),
            .div      (div[g*DIV_W +: DIV_W]),
            .phase    (phase[g*DIV_W +: DIV_W]),
            .strobe   (strobe[g])
        );
    end

endmodule

// File: tb/tb_clk_strobe_gen.sv
// Randomized scoreboard bench for clk_strobe_gen against a lock-history reference model.
module tb_clk_strobe_gen;
    localparam int NUM_CH = 2;
    localparam int DIV_W  = 16;
    localparam int D      = 64;
    localparam int MAXC   = 4000;
`ifdef CLK_STROBE_GEN_LOCK_SYNC_EN
    localparam int L = 2;
`else
    localparam int L = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pll_locked = 1'b0;
    logic cfg_load = 1'b0;
    logic [NUM_CH*DIV_W-1:0] div = '0;
    logic [NUM_CH*DIV_W-1:0] phase = '0;
    logic [NUM_CH-1:0] strobe;
    logic ready, lost_lock;

    always #5 clk = ~clk;

    clk_strobe_gen #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .LOCK_DLY(D)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .div        (div),
        .phase      (phase),
        .cfg_load   (cfg_load),
        .strobe     (strobe),
        .ready      (ready),
        .lost_lock  (lost_lock)
    );

    typedef struct packed {
        int                cyc;
        logic [NUM_CH-1:0] stb;
        logic              rdy;
        logic              lost;
    } exp_t;

    exp_t sb[$];
    int n_vec = 0;
    int n_err = 0;

    bit pll_a[MAXC];
    bit rst_a[MAXC];
    bit cfg_a[MAXC];
    int cyc = 0;
    int run_len = 0;
    bit run_prev = 0;
    bit lost_m = 0;
    int sh_div[NUM_CH], sh_ph[NUM_CH];
    int an_cyc[NUM_CH], an_div[NUM_CH], an_ph[NUM_CH];
    int in_div[NUM_CH], in_ph[NUM_CH], nx_div[NUM_CH], nx_ph[NUM_CH];

    // Synchronized lock as seen in cycle j: the raw lock L cycles earlier, unless a reset intervened.
    function automatic bit lock_s_m(input int j);
        if (j < L || j < 0) return 1'b0;
        for (int i = j - L; i < j; i++)
            if (rst_a[i]) return 1'b0;
        return pll_a[j - L];
    endfunction

    function automatic bit eff(input int j);
        if (j < 0) return 1'b0;
        return lock_s_m(j) && !rst_a[j];
    endfunction

    // Model the outputs of cycle `cyc` from input history, then drive the inputs for this cycle.
    task automatic step(input bit r, input bit p, input bit c);
        int   k;
        bit   run_k;
        int   de, pe;
        exp_t e;
        k = cyc;
        if (k >= 1) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (rst_a[k-1]) begin
                    sh_div[ch] = 1;
                    sh_ph[ch]  = 0;
                end else if (cfg_a[k-1]) begin
                    sh_div[ch] = in_div[ch];
                    sh_ph[ch]  = in_ph[ch];
                end
            end
            if (rst_a[k-1])                          lost_m = 1'b0;
            else if (eff(k-2) && !lock_s_m(k-1))     lost_m = 1'b1;
            else if (cfg_a[k-1])                     lost_m = 1'b0;
            // RUN needs the lock held for the whole settle window plus the detecting cycle.
            run_len = eff(k-1) ? run_len + 1 : 0;
            run_k   = (run_len >= D + 1);
            e.cyc = k;
            e.stb = '0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (run_k && (!run_prev || cfg_a[k-1])) begin
                    de = (sh_div[ch] == 0) ? 1 : sh_div[ch];
                    pe = (sh_ph[ch] > de - 1) ? de - 1 : sh_ph[ch];
                    an_cyc[ch] = k;
                    an_div[ch] = de;
                    an_ph[ch]  = pe;
                end
                e.stb[ch] = run_k && (((k - an_cyc[ch] + an_ph[ch]) % an_div[ch]) == an_div[ch] - 1);
            end
            e.rdy  = run_k;
            e.lost = lost_m;
            run_prev = run_k;
            sb.push_back(e);
        end
        rst_n      = !r;
        pll_locked = p;
        cfg_load   = c;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            div[ch*DIV_W +: DIV_W]   = DIV_W'(nx_div[ch]);
            phase[ch*DIV_W +: DIV_W] = DIV_W'(nx_ph[ch]);
            in_div[ch] = nx_div[ch];
            in_ph[ch]  = nx_ph[ch];
        end
        rst_a[k] = r;
        pll_a[k] = p;
        cfg_a[k] = c;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_vec++;
            if (strobe !== e.stb) begin
                n_err++;
                $display("FAIL strobe cyc %0d: got %b want %b", e.cyc, strobe, e.stb);
            end
            n_vec++;
            if (ready !== e.rdy) begin
                n_err++;
                $display("FAIL ready cyc %0d: got %b want %b", e.cyc, ready, e.rdy);
            end
            n_vec++;
            if (lost_lock !== e.lost) begin
                n_err++;
                $display("FAIL lost_lock cyc %0d: got %b want %b", e.cyc, lost_lock, e.lost);
            end
        end
    end

    initial begin
        bit p;
        bit r;
        bit c;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            nx_div[ch] = 1; nx_ph[ch] = 0; in_div[ch] = 1; in_ph[ch] = 0;
            sh_div[ch] = 1; sh_ph[ch] = 0;
            an_cyc[ch] = 0; an_div[ch] = 1; an_ph[ch] = 0;
        end
        repeat (3) step(1, 0, 0);

        // div 4 / phase 0 and div 1 loaded before lock
        nx_div[0] = 4; nx_ph[0] = 0; nx_div[1] = 1; nx_ph[1] = 0;
        step(0, 0, 1);
        repeat (5) step(0, 0, 0);
        repeat (110) step(0, 1, 0);

        // phase clamp (5/9) and div 0
        nx_div[0] = 5; nx_ph[0] = 9; nx_div[1] = 0; nx_ph[1] = 3;
        step(0, 1, 1);
        repeat (30) step(0, 1, 0);

        // mid-RUN reconfiguration
        nx_div[0] = 3; nx_ph[0] = 1; nx_div[1] = 4; nx_ph[1] = 2;
        step(0, 1, 1);
        repeat (20) step(0, 1, 0);

        // lock drop, relock, then clear lost_lock
        repeat (10) step(0, 0, 0);
        repeat (100) step(0, 1, 0);
        step(0, 1, 1);
        repeat (20) step(0, 1, 0);

        // one-cycle reset during RUN
        step(1, 1, 0);
        repeat (100) step(0, 1, 0);

        // lock drop coinciding with cfg_load
        nx_div[0] = 2; nx_ph[0] = 1;
        step(0, 0, 1);
        repeat (5) step(0, 0, 0);

        p = 1'b1;
        repeat (2400) begin
            if ($urandom_range(0, 299) == 0) p = !p;
            r = ($urandom_range(0, 999) == 0);
            c = ($urandom_range(0, 19) == 0);
            if (c) begin
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    nx_div[ch] = $urandom_range(0, 7);
                    nx_ph[ch]  = $urandom_range(0, 9);
                end
            end
            step(r, p, c);
        end

        for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
